// File: rtl/reg_bank_16x16_pkg.sv
// Shared widths and sequencer state type for the PT1 register bank.
// The downstream word mux reuses the same width constants.
package cpu_regbank_pkg;
  localparam int WORD_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/reg_bank_16x16_if.sv
// Write/clear bus of the register bank, including the flattened data output.
interface reg_bank_16x16_if;
  import cpu_regbank_pkg::*;

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [WORD_W-1:0]          wr_data;
  logic                       clr_req;
  logic                       busy;
  logic                       clr_done;
  logic                       wr_reject;
  logic [NUM_REGS-1:0]        dirty;
  logic [NUM_REGS*WORD_W-1:0] data_bus_out;

  modport master (
    output wr_en, wr_addr, wr_data, clr_req,
    input  busy, clr_done, wr_reject, dirty, data_bus_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr_req,
    output busy, clr_done, wr_reject, dirty, data_bus_out
  );
endinterface

// File: rtl/reg_bank_16x16_clear_seq.sv
// Clear-sweep sequencer: walks ptr over every register once per request.
//   state | meaning
//   IDLE  | no sweep; writes accepted, clr_req starts a sweep
//   CLEAR | zeroing register ptr this cycle, ascending
module reg_clear_seq
  import cpu_regbank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_active,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              busy,
  output logic              clr_done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      clr_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == ADDR_W'(NUM_REGS - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_active = (state == CLEAR);
  assign busy       = clr_active;
  assign clr_idx    = ptr;

endmodule

// File: rtl/reg_bank_16x16.sv
// Sixteen 16-bit registers with one write port, dirty mask and sweep clear,
// driving the flattened bus of the downstream word mux.
module reg_bank_16x16
  import cpu_regbank_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  reg_bank_16x16_if.slave  bus
);

  logic [WORD_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q;
  logic                wr_reject_q;
  logic                clr_active;
  logic [ADDR_W-1:0]   clr_idx;
  logic                busy;
  logic                clr_done;

  reg_clear_seq u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (bus.clr_req),
    .clr_active (clr_active),
    .clr_idx    (clr_idx),
    .busy       (busy),
    .clr_done   (clr_done)
  );

  // Sweep and write never collide: writes are only taken while not busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      dirty_q     <= '0;
      wr_reject_q <= 1'b0;
    end else begin
      wr_reject_q <= bus.wr_en & busy;
      if (clr_active) begin
        regs[clr_idx]    <= '0;
        dirty_q[clr_idx] <= 1'b0;
      end else if (bus.wr_en) begin
        regs[bus.wr_addr]    <= bus.wr_data;
        dirty_q[bus.wr_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_bus
    assign bus.data_bus_out[k*WORD_W +: WORD_W] = regs[k];
  end

  assign bus.busy      = busy;
  assign bus.clr_done  = clr_done;
  assign bus.wr_reject = wr_reject_q;
  assign bus.dirty     = dirty_q;

endmodule
